spi_dc_cmd_sequencer: RTL and testbench

//  Queues {type,byte} entries written over AXI4-Lite and plays them into the SPI D/C shifter.

---
 rtl/spi_dc_cmd_sequencer_if.sv | 47 ++++
 rtl/spi_dc_cmd_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_dc_cmd_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_dc_cmd_sequencer_if.sv
// Push, shifter and status bundle for spi_dc_cmd_sequencer.
// irq/irq_clr exist only when SPI_DC_SEQ_IRQ_EN is defined.
interface spi_dc_cmd_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          enable;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [9:0]    wr_entry;
  logic [LW-1:0] fifo_level;
  logic          busy;
  logic          shf_valid;
  logic          shf_ready;
  logic          shf_dc;
  logic [7:0]    shf_data;
  logic          shf_done;
  logic          spi_cs_n;
`ifdef SPI_DC_SEQ_IRQ_EN
  logic          irq;
  logic          irq_clr;
`endif

  modport slave (
`ifdef SPI_DC_SEQ_IRQ_EN
    input  irq_clr,
    output irq,
`endif
    input  enable, flush, wr_valid, wr_entry,
    input  shf_ready, shf_done,
    output wr_ready, fifo_level, busy,
    output shf_valid, shf_dc, shf_data, spi_cs_n
  );

  modport master (
`ifdef SPI_DC_SEQ_IRQ_EN
    output irq_clr,
    input  irq,
`endif
    output enable, flush, wr_valid, wr_entry,
    output shf_ready, shf_done,
    input  wr_ready, fifo_level, busy,
    input  shf_valid, shf_dc, shf_data, spi_cs_n
  );
endinterface

// File: rtl/spi_dc_cmd_sequencer.sv
// Command FIFO plus CS-framing FSM feeding the SPI D/C byte shifter.
// Optional level irq on frame close: define SPI_DC_SEQ_IRQ_EN.
module spi_dc_cmd_sequencer #(
  parameter int DEPTH        = 16,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2,
  parameter int DELAY_TICK   = 100,
  parameter int IDLE_TO_CYC  = 64
) (
  input logic ACLK,
  input logic ARESET,
  spi_dc_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, DISPATCH, WAIT_DONE, DELAY, CS_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   idle_q, idle_d;
  logic          cs_n_q, cs_n_d;
  logic          vld_q, vld_d;
  logic          dc_q, dc_d;
  logic [7:0]    data_q, data_d;
  logic          fpend_q, fpend_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [9:0]    mem_q [DEPTH];

  logic       empty, push, pop, pop_en;
  logic       disp, ok, hs;
  logic [9:0] head;

  assign head   = mem_q[rp_q];
  assign empty  = (lvl_q == '0);
  assign push   = bus.wr_valid && bus.wr_ready && !bus.flush;
  assign pop_en = pop && !empty && !bus.flush;
  assign hs     = vld_q && bus.shf_ready;
  assign ok     = bus.enable && !bus.flush && !fpend_q;

  always_comb begin
    wp_d  = wp_q + AW'(push);
    rp_d  = rp_q + AW'(pop_en);
    lvl_d = lvl_q + LW'(push) - LW'(pop_en);
    if (bus.flush) begin
      wp_d  = '0;
      rp_d  = '0;
      lvl_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = '0;
    cs_n_d  = cs_n_q;
    vld_d   = vld_q;
    dc_d    = dc_q;
    data_d  = data_q;
    fpend_d = 1'b0;
    pop     = 1'b0;
    disp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable && !empty && !bus.flush) begin
          if (head[9:8] == 2'b11) begin
            pop = 1'b1;
          end else begin
            cs_n_d  = 1'b0;
            cnt_d   = 32'(CS_SETUP_CYC);
            state_d = CS_SETUP;
          end
        end
      end
      CS_SETUP: begin
        fpend_d = fpend_q || bus.flush;
        if (cnt_q == '0) disp = 1'b1;
        else cnt_d = cnt_q - 32'd1;
      end
      DISPATCH: begin
        if (!vld_q) begin
          disp = 1'b1;
        end else if (hs) begin
          pop     = 1'b1;
          vld_d   = 1'b0;
          fpend_d = bus.flush;
          state_d = WAIT_DONE;
        end else if (bus.flush) begin
          vld_d   = 1'b0;
          cnt_d   = 32'(CS_HOLD_CYC);
          state_d = CS_HOLD;
        end
      end
      WAIT_DONE: begin
        fpend_d = fpend_q || bus.flush;
        if (bus.shf_done) disp = 1'b1;
      end
      DELAY: begin
        if (bus.flush) begin
          cnt_d   = 32'(CS_HOLD_CYC);
          state_d = CS_HOLD;
        end else if (cnt_q <= 32'd1) begin
          disp = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      CS_HOLD: begin
        if (cnt_q <= 32'd1) begin
          cs_n_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared head-entry decision, also taken on the exit edge of
    // CS_SETUP/WAIT_DONE/DELAY so no dead DISPATCH cycle is inserted.
    if (disp) begin
      fpend_d = 1'b0;
      if (!ok) begin
        cnt_d   = 32'(CS_HOLD_CYC);
        state_d = CS_HOLD;
      end else if (empty) begin
        state_d = DISPATCH;
        if (state_q == DISPATCH) begin
          idle_d = idle_q + 32'd1;
          if (!push && idle_q + 32'd1 >= 32'(IDLE_TO_CYC)) begin
            cnt_d   = 32'(CS_HOLD_CYC);
            state_d = CS_HOLD;
          end
        end
      end else begin
        case (head[9:8])
          2'b10: begin
            pop     = 1'b1;
            cnt_d   = 32'(head[7:0]) * 32'(DELAY_TICK);
            state_d = DELAY;
          end
          2'b11: begin
            pop     = 1'b1;
            cnt_d   = 32'(CS_HOLD_CYC);
            state_d = CS_HOLD;
          end
          default: begin
            vld_d   = 1'b1;
            dc_d    = head[8];
            data_d  = head[7:0];
            state_d = DISPATCH;
          end
        endcase
      end
    end
    if (push) idle_d = '0;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      cs_n_q  <= 1'b1;
      vld_q   <= 1'b0;
      dc_q    <= 1'b0;
      data_q  <= '0;
      fpend_q <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      cs_n_q  <= cs_n_d;
      vld_q   <= vld_d;
      dc_q    <= dc_d;
      data_q  <= data_d;
      fpend_q <= fpend_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      lvl_q   <= lvl_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wp_q] <= bus.wr_entry;
  end

  assign bus.wr_ready   = (lvl_q != LW'(DEPTH));
  assign bus.fifo_level = lvl_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.shf_valid  = vld_q;
  assign bus.shf_dc     = dc_q;
  assign bus.shf_data   = data_q;
  assign bus.spi_cs_n   = cs_n_q;

`ifdef SPI_DC_SEQ_IRQ_EN
  logic irq_q, irq_d, irq_set;

  assign irq_set = (state_q == CS_HOLD) && (state_d == IDLE);

  always_comb begin
    irq_d = irq_q;
    if (bus.irq_clr) irq_d = 1'b0;
    if (irq_set) irq_d = 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end

  assign bus.irq = irq_q;
`endif
endmodule

// File: tb/tb_spi_dc_cmd_sequencer.sv
// Scoreboard bench for spi_dc_cmd_sequencer (irq checks need SPI_DC_SEQ_IRQ_EN).
module tb_spi_dc_cmd_sequencer;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  spi_dc_cmd_sequencer_if #(.DEPTH(16)) bus ();
  spi_dc_cmd_sequencer dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_push = 0;
  int acc_n = 0;
  int falls = 0, rises = 0;
  int cs_fall = -1, cs_rise = -1;
  logic [8:0] exp_q[$];
  int vrise_q[$];
  int done_q[$];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  // Monitor: scoreboard on every accepted byte, plus edge timestamps.
  initial begin : monitor
    logic vprev, csprev;
    logic [8:0] e;
    vprev = 1'b0;
    csprev = 1'b1;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        vprev = 1'b0;
        csprev = 1'b1;
      end else begin
        if (bus.shf_valid && !vprev) vrise_q.push_back(cyc);
        vprev = bus.shf_valid;
        if (bus.shf_valid && bus.shf_ready) begin
          acc_n++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra actual=%h required=none", {bus.shf_dc, bus.shf_data});
          end else begin
            e = exp_q.pop_front();
            chk("sb_byte", int'({bus.shf_dc, bus.shf_data}), int'(e));
          end
        end
        if (bus.spi_cs_n != csprev) begin
          if (csprev) begin
            falls++;
            cs_fall = cyc;
          end else begin
            rises++;
            cs_rise = cyc;
          end
        end
        csprev = bus.spi_cs_n;
      end
    end
  end

  initial begin : shifter
    forever begin
      @(negedge ACLK);
      if (!ARESET && bus.shf_valid && bus.shf_ready) begin
        repeat (8) @(posedge ACLK);
        #1;
        bus.shf_done = 1'b1;
        done_q.push_back(cyc + 1);
        @(posedge ACLK);
        #1;
        bus.shf_done = 1'b0;
      end
    end
  end

  task automatic push(input logic [9:0] e);
    bus.wr_valid = 1'b1;
    bus.wr_entry = e;
    @(posedge ACLK);
    #1;
    last_push = cyc;
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_frame(input int lim, input string nm);
    int n;
    n = 0;
    while (!bus.busy && n < lim) begin
      @(negedge ACLK);
      n++;
    end
    while ((bus.busy || !bus.spi_cs_n) && n < lim) begin
      @(negedge ACLK);
      n++;
    end
    chk(nm, int'(bus.busy), 0);
  endtask

  task automatic clear_logs();
    vrise_q.delete();
    done_q.delete();
  endtask

  function automatic int last_done();
    return (done_q.size() > 0) ? done_q[done_q.size()-1] : -1000;
  endfunction

  initial begin : stim
    int k, f0, r0, a0, n;
    bus.enable = 1'b0;
    bus.flush = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_entry = '0;
    bus.shf_ready = 1'b1;
    bus.shf_done = 1'b0;
`ifdef SPI_DC_SEQ_IRQ_EN
    bus.irq_clr = 1'b0;
`endif
    repeat (2) @(negedge ACLK);
    chk("rst_cs_n", int'(bus.spi_cs_n), 1);
    chk("rst_valid", int'(bus.shf_valid), 0);
    chk("rst_dc", int'(bus.shf_dc), 0);
    chk("rst_data", int'(bus.shf_data), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_level", int'(bus.fifo_level), 0);
    chk("rst_wr_ready", int'(bus.wr_ready), 1);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    bus.enable = 1'b1;

    // CMD, DATA, DATA, END
    clear_logs();
    f0 = falls;
    exp_q.push_back(9'h02A);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h1EF);
    push(10'h02A);
    k = last_push;
    push(10'h100);
    push(10'h1EF);
    push(10'h300);
    wait_frame(300, "s1_frame_end");
    chk("s1_cs_fall", cs_fall, k + 1);
    chk("s1_first_valid", (vrise_q.size() > 0) ? vrise_q[0] : -1, k + 4);
    chk("s1_cs_rise_after_done", cs_rise, last_done() + 2);
    chk("s1_frames", falls - f0, 1);
`ifdef SPI_DC_SEQ_IRQ_EN
    chk("s6_irq_set", int'(bus.irq), 1);
    @(posedge ACLK);
    #1;
    bus.irq_clr = 1'b1;
    @(posedge ACLK);
    #1;
    bus.irq_clr = 1'b0;
    @(negedge ACLK);
    chk("s6_irq_clr", int'(bus.irq), 0);
`endif

    // DELAY 3 between two CMDs
    clear_logs();
    f0 = falls;
    r0 = rises;
    exp_q.push_back(9'h011);
    exp_q.push_back(9'h022);
    push(10'h011);
    push(10'h203);
    push(10'h022);
    push(10'h300);
    wait_frame(1000, "s2_frame_end");
    chk_rng("s2_delay_gap",
            ((vrise_q.size() > 1) ? vrise_q[1] : 0) - ((done_q.size() > 0) ? done_q[0] : 0),
            299, 301);
    chk("s2_cs_falls", falls - f0, 1);
    chk("s2_cs_rises", rises - r0, 1);

    // Overfill with enable low
    bus.enable = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push(10'h100 | 10'(i));
      if (i < 16) exp_q.push_back(9'h100 | 9'(i));
    end
    @(negedge ACLK);
    chk("s3_wr_ready_full", int'(bus.wr_ready), 0);
    chk("s3_level_full", int'(bus.fifo_level), 16);
    bus.enable = 1'b1;
    wait_frame(1000, "s3_frame_end");
    chk("s3_level_drained", int'(bus.fifo_level), 0);

    // Flush during WAIT_DONE of byte 2 of 5
    clear_logs();
    a0 = acc_n;
    exp_q.push_back(9'h041);
    exp_q.push_back(9'h042);
    for (int i = 1; i <= 5; i++) push(10'h040 | 10'(i));
    push(10'h300);
    n = 0;
    while (acc_n < a0 + 2 && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    chk("s4_second_accept", acc_n - a0, 2);
    @(posedge ACLK);
    #1;
    bus.flush = 1'b1;
    @(posedge ACLK);
    #1;
    bus.flush = 1'b0;
    @(negedge ACLK);
    chk("s4_level_flushed", int'(bus.fifo_level), 0);
    wait_frame(300, "s4_frame_end");
    chk("s4_accepts", acc_n - a0, 2);
    chk("s4_valid_rises", vrise_q.size(), 2);
    chk("s4_cs_rise_after_done", cs_rise, last_done() + 2);

    // Lone CMD, idle timeout; then lone END
    clear_logs();
    exp_q.push_back(9'h05A);
    push(10'h05A);
    wait_frame(400, "s5_frame_end");
    chk("s5_idle_timeout", cs_rise, last_done() + 66);
    f0 = falls;
    push(10'h300);
    repeat (4) @(negedge ACLK);
    chk("s5_end_popped", int'(bus.fifo_level), 0);
    chk("s5_end_no_cs", falls - f0, 0);
    chk("s5_end_busy", int'(bus.busy), 0);

    // Asynchronous reset mid-frame
    push(10'h077);
    @(posedge ACLK);
    #2;
    chk("rst_mid_pre_cs", int'(bus.spi_cs_n), 0);
`ifdef SPI_DC_SEQ_IRQ_EN
    chk("rst_mid_pre_irq", int'(bus.irq), 1);
`endif
    #1;
    ARESET = 1'b1;
    #1;
    chk("rst_mid_cs_n", int'(bus.spi_cs_n), 1);
    chk("rst_mid_level", int'(bus.fifo_level), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
`ifdef SPI_DC_SEQ_IRQ_EN
    chk("rst_mid_irq", int'(bus.irq), 0);
`endif
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    repeat (12) @(negedge ACLK);
    chk("rst_mid_idle_after", int'(bus.spi_cs_n), 1);

    chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
